// File: rtl/counter_ctrl_pkg.sv
// Shared constants for the button-driven counter controller.
// State codes double as the debug state output.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam int DEF_DB_CYCLES = 100000;
  localparam int DEF_NUM_MODES = 2;

endpackage

// File: rtl/counter_ctrl_param_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, debounce counter, rise detector.
// btn_pulse is high for the one cycle after the debounced level rises.
module btn_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      btn_level <= 1'b0;
      level_d   <= 1'b0;
      cnt       <= '0;
    end else begin
      sync1   <= btn_in;
      sync2   <= sync1;
      level_d <= btn_level;
      // any agreement with the current level restarts the count
      if (sync2 != btn_level) begin
        if (cnt == LAST) begin
          btn_level <= sync2;
          cnt       <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign btn_pulse = btn_level & ~level_d;

endmodule

// File: rtl/counter_ctrl_param.sv
// Run/stop/clear controller with cyclic mode select,
// driven by three raw push buttons.
module counter_ctrl_param
  import counter_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int NUM_MODES = DEF_NUM_MODES,
  parameter int MODE_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_enable,
  input  logic              btn_clear,
  input  logic              btn_mode,
  output logic              enable,
  output logic              clear,
  output logic [MODE_W-1:0] mode,
  output logic [1:0]        state
);

  localparam logic [MODE_W-1:0] MODE_LAST =
    MODE_W'(NUM_MODES - 1);

  logic   en_p;
  logic   clr_p;
  logic   md_p;
  state_e state_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_en (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_enable),
    .btn_level (),
    .btn_pulse (en_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_clear),
    .btn_level (),
    .btn_pulse (clr_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_md (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_mode),
    .btn_level (),
    .btn_pulse (md_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STOP;
      enable  <= 1'b0;
      clear   <= 1'b0;
      mode    <= '0;
    end else begin
      unique case (state_q)
        STOP, RUN: begin
          // clear wins; a coincident enable pulse is dropped
          if (clr_p) begin
            state_q <= CLEAR;
            enable  <= 1'b0;
            clear   <= 1'b1;
          end else if (en_p) begin
            state_q <= (state_q == STOP) ? RUN : STOP;
            enable  <= (state_q == STOP);
          end
          if (md_p) begin
            mode <= (mode == MODE_LAST) ? '0
                                        : mode + MODE_W'(1);
          end
        end
        CLEAR: begin
          state_q <= STOP;
          enable  <= 1'b0;
          clear   <= 1'b0;
        end
        default: begin
          state_q <= STOP;
          enable  <= 1'b0;
          clear   <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_counter_ctrl_param.sv
// Directed bench for counter_ctrl_param with DB_CYCLES=4, NUM_MODES=3.
// Press latency is 7 edges from the first edge sampling the button.
module tb_counter_ctrl_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_enable;
  logic       btn_clear;
  logic       btn_mode;
  logic       enable;
  logic       clear;
  logic [3:0] mode;
  logic [1:0] state;

  int total  = 0;
  int passed = 0;

  counter_ctrl_param #(
    .DB_CYCLES (4),
    .NUM_MODES (3),
    .MODE_W    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_enable (btn_enable),
    .btn_clear  (btn_clear),
    .btn_mode   (btn_mode),
    .enable     (enable),
    .clear      (clear),
    .mode       (mode),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic       clr;
    logic       md;
    logic [7:0] hold;
    logic       x_en;
    logic       x_clr;
    logic [3:0] x_mode;
    logic [1:0] x_st;
  } vec_t;

  vec_t vecs [0:22];

  function automatic vec_t mk(
    input logic en, input logic clr, input logic md,
    input int hold, input logic x_en, input logic x_clr,
    input int x_mode, input int x_st);
    vec_t v;
    v.en     = en;
    v.clr    = clr;
    v.md     = md;
    v.hold   = 8'(hold);
    v.x_en   = x_en;
    v.x_clr  = x_clr;
    v.x_mode = 4'(x_mode);
    v.x_st   = 2'(x_st);
    return v;
  endfunction

  task automatic check(input string name,
                       input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, act, exp);
  endtask

  task automatic check_all(input string tag,
    input logic x_en, input logic x_clr,
    input int x_mode, input int x_st);
    check({tag, ".enable"}, int'(enable), int'(x_en));
    check({tag, ".clear"},  int'(clear),  int'(x_clr));
    check({tag, ".mode"},   int'(mode),   x_mode);
    check({tag, ".state"},  int'(state),  x_st);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic clr,
                       input logic md);
    btn_enable = en;
    btn_clear  = clr;
    btn_mode   = md;
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 0, 6,  0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 1,  1, 0, 0, 1);
    vecs[2]  = mk(1, 0, 0, 13, 1, 0, 0, 1);
    vecs[3]  = mk(0, 0, 0, 10, 1, 0, 0, 1);
    vecs[4]  = mk(0, 0, 1, 6,  1, 0, 0, 1);
    vecs[5]  = mk(0, 0, 1, 1,  1, 0, 1, 1);
    vecs[6]  = mk(0, 0, 0, 10, 1, 0, 1, 1);
    vecs[7]  = mk(0, 0, 1, 7,  1, 0, 2, 1);
    vecs[8]  = mk(0, 0, 0, 10, 1, 0, 2, 1);
    vecs[9]  = mk(0, 0, 1, 7,  1, 0, 0, 1);
    vecs[10] = mk(0, 0, 0, 10, 1, 0, 0, 1);
    vecs[11] = mk(0, 0, 1, 7,  1, 0, 1, 1);
    vecs[12] = mk(0, 0, 0, 10, 1, 0, 1, 1);
    vecs[13] = mk(0, 1, 0, 6,  1, 0, 1, 1);
    vecs[14] = mk(0, 1, 0, 1,  0, 1, 1, 2);
    vecs[15] = mk(0, 1, 0, 1,  0, 0, 1, 0);
    vecs[16] = mk(0, 0, 0, 10, 0, 0, 1, 0);
    vecs[17] = mk(1, 1, 0, 7,  0, 1, 1, 2);
    vecs[18] = mk(1, 1, 0, 1,  0, 0, 1, 0);
    vecs[19] = mk(1, 1, 0, 12, 0, 0, 1, 0);
    vecs[20] = mk(0, 0, 0, 10, 0, 0, 1, 0);
    vecs[21] = mk(1, 0, 1, 7,  1, 0, 2, 1);
    vecs[22] = mk(0, 0, 0, 10, 1, 0, 2, 1);

    rst = 1'b1;
    drive(0, 0, 0);
    edges(2);
    check_all("reset", 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i <= 22; i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].md);
      edges(int'(vecs[i].hold));
      check_all($sformatf("vec%0d", i), vecs[i].x_en,
                vecs[i].x_clr, int'(vecs[i].x_mode),
                int'(vecs[i].x_st));
    end

    // reset in RUN with mode=2 while btn_mode is held
    rst = 1'b1;
    drive(0, 0, 1);
    edges(1);
    check_all("rst_run", 0, 0, 0, 0);
    rst = 1'b0;
    edges(6);
    check_all("rst_held6", 0, 0, 0, 0);
    edges(1);
    check_all("rst_held7", 0, 0, 1, 0);
    edges(10);
    check_all("rst_hold", 0, 0, 1, 0);
    drive(0, 0, 0);
    edges(10);

    // bursts shorter than the debounce window
    for (int b = 0; b < 2; b++) begin
      drive(1, 0, 0);
      edges(3);
      drive(0, 0, 0);
      edges(3);
    end
    check_all("bounce", 0, 0, 1, 0);
    drive(1, 0, 0);
    edges(6);
    check_all("stable6", 0, 0, 1, 0);
    edges(1);
    check_all("stable7", 1, 0, 1, 1);
    edges(3);
    check_all("stable10", 1, 0, 1, 1);
    drive(0, 0, 0);
    edges(10);
    check_all("stable_rel", 1, 0, 1, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/counter_ctrl_param.md
COUNTER_CTRL_PARAM -- requirements
Module: counter_ctrl_param

Interface
REQ-001 Parameter DB_CYCLES, default 100000: consecutive stable cycles before a button level is accepted; legal range 1..2^20.
REQ-002 Parameter NUM_MODES, default 2: number of counter modes selectable by btn_mode; legal range 2..16.
REQ-003 Parameter MODE_W, default 4: mode output width; must satisfy 2^MODE_W >= NUM_MODES.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 btn_enable  input  1  raw asynchronous run/stop button.
REQ-007 btn_clear  input  1  raw asynchronous clear button.
REQ-008 btn_mode  input  1  raw asynchronous mode-select button.
REQ-009 enable  output  1  counter run enable, registered.
REQ-010 clear  output  1  one-cycle counter clear pulse, registered.
REQ-011 mode  output  MODE_W  current mode index 0..NUM_MODES-1, registered.
REQ-012 state  output  2  FSM state code for debug: 0 STOP, 1 RUN, 2 CLEAR.

Function
REQ-013 Each button passes through a 2-FF synchroniser, then a debounce counter, then a rising-edge detector producing a one-cycle pulse.
REQ-014 Debounce: the debounced level changes only after the synchronised input has differed from it for DB_CYCLES consecutive cycles; any reversion restarts the count from 0.
REQ-015 Latency: for a clean press, the affected output changes exactly DB_CYCLES+3 rising edges after the first edge sampling the button high.
REQ-016 Release, held press, and bounce shorter than DB_CYCLES produce no pulse.
REQ-017 FSM states STOP, RUN, CLEAR; enable=1 only in RUN; clear=1 only in CLEAR.
REQ-018 STOP + enable pulse -> RUN; RUN + enable pulse -> STOP.
REQ-019 STOP or RUN + clear pulse -> CLEAR; CLEAR -> STOP unconditionally on the next cycle.
REQ-020 Clear pulse has priority over a same-cycle enable pulse; that enable pulse is discarded.
REQ-021 Pulses arriving while in CLEAR are discarded; the enable pulse is not queued.
REQ-022 Mode pulse in STOP or RUN increments mode modulo NUM_MODES (NUM_MODES-1 wraps to 0); enable state is unaffected.
REQ-023 Mode pulse in CLEAR is discarded; CLEAR does not change mode.
REQ-024 Mode and enable/clear pulses in the same cycle are both applied.

Reset
REQ-025 While rst=1 at a clock edge: state=STOP, enable=0, clear=0, mode=0; synchronisers, debounce counters, debounced levels and edge detectors cleared to 0.
REQ-026 Reset mid-operation, including in CLEAR or mid-debounce, takes effect at the next edge; no pulse is emitted from pre-reset activity.
REQ-027 A button already held high when rst deasserts is debounced afresh and produces one pulse after DB_CYCLES+3 edges.

Structure
REQ-028 Shared package counter_ctrl_pkg holds the state encoding constants (STOP=2'd0, RUN=2'd1, CLEAR=2'd2) and the default DB_CYCLES and NUM_MODES.
REQ-029 Sub-module btn_debounce (parameter DB_CYCLES; ports clk, rst, btn_in, btn_level, btn_pulse) is instantiated once per button.
REQ-030 The debounce counter width is $clog2(DB_CYCLES+1); mode arithmetic is done at MODE_W bits with explicit wrap compare.

Verification (DB_CYCLES=4, NUM_MODES=3)
REQ-031 Reset, clean btn_enable press held for 20 cycles -> enable rises exactly 7 edges after the press; single toggle only; state=1.
REQ-032 btn_enable bounces 1-0-1-0 in 3-cycle bursts, then a stable 10-cycle press -> exactly one toggle, after the stable press.
REQ-033 In RUN, btn_mode pressed 3 times -> mode 1, 2, 0; enable stays 1.
REQ-034 In RUN, btn_clear pressed -> clear=1 for exactly one cycle with state=2, then state=0 and enable=0; mode unchanged.
REQ-035 btn_clear and btn_enable pressed on the same edge from STOP -> CLEAR then STOP; enable never rises.
REQ-036 rst asserted for 1 cycle while in RUN with mode=2 -> next edge enable=0, mode=0, state=0; held btn_mode yields one pulse 7 edges after rst deasserts.
